// File: rtl/dmem_if.sv
// Request/response bus between the MEM stage and dmem_ctrl.
// Handshake: a request transfers on a rising edge where req_valid and req_ready are both 1; resp_valid is a single-cycle strobe qualifying resp_rdata/resp_fault.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface

// File: rtl/dmem_ctrl.sv
// RISC-V byte/half/word data memory with wait states and a single-cycle response.
// Define DMEM_FAULT_EN to detect misaligned, out-of-range and illegal-size requests.
module dmem_ctrl #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    dmem_if.slave      bus,
    output logic [1:0] state_dbg
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_fault_q;

    // Behavioural array: zero at time zero, never reset.
    logic [31:0] mem [DEPTH] = '{default: 32'h0};

    logic [AW-1:0] idx;
    logic          is_byte, is_half, illegal, fault;
    logic [1:0]    lane;
    logic [31:0]   bmask, wword, rword, load_data;

    assign idx = addr_q[AW+1:2];

    always_comb begin
        illegal = (f3_q == 3'b011) || (f3_q[2:1] == 2'b11) || (we_q && f3_q[2]);
        // Illegal codes fall back to a word access.
        is_byte = (f3_q[1:0] == 2'b00) && !illegal;
        is_half = (f3_q[1:0] == 2'b01) && !illegal;
`ifdef DMEM_FAULT_EN
        fault = illegal
             || (is_half && addr_q[0])
             || (!is_byte && !is_half && (addr_q[1:0] != 2'b00))
             || (|addr_q[31:AW+2]);
`else
        fault = 1'b0;
`endif
        lane  = is_byte ? addr_q[1:0] : (is_half ? {addr_q[1], 1'b0} : 2'b00);
        bmask = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (is_byte ? (lane == 2'(i)) : (is_half ? (lane[1] == (i >= 2)) : 1'b1))
                bmask[8*i +: 8] = 8'hFF;
        end
        wword = is_byte ? {4{wdata_q[7:0]}} : (is_half ? {2{wdata_q[15:0]}} : wdata_q);
        rword = mem[idx] >> {lane, 3'b000};
        if (is_byte)
            load_data = {{24{rword[7] & ~f3_q[2]}}, rword[7:0]};
        else if (is_half)
            load_data = {{16{rword[15] & ~f3_q[2]}}, rword[15:0]};
        else
            load_data = rword;
    end

`ifndef DMEM_FAULT_EN
    logic unused_hi_addr;
    assign unused_hi_addr = ^{addr_q[31:AW+2], illegal};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_fault_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        f3_q    <= bus.req_funct3;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        cnt     <= 4'(WAIT_CYCLES);
                        ready_q <= 1'b0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        resp_rdata_q <= (fault || we_q) ? 32'h0 : load_data;
                        resp_fault_q <= fault;
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    ready_q      <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Commit on the access edge, so the write lands before the RESP cycle.
    always_ff @(posedge clk) begin
        if (!rst && state == BUSY && cnt == 4'd0 && we_q && !fault)
            mem[idx] <= (mem[idx] & ~bmask) | (wword & bmask);
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_fault = resp_fault_q;
    assign state_dbg      = state;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: one instance with 0 wait states and one with 3, checked against a byte-array model.
module tb_dmem_ctrl;
    localparam int DEPTH  = 64;
    localparam int NBYTES = DEPTH * 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_if b0 ();
    dmem_if b3 ();
    logic [1:0] st0, st3;

    dmem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave), .state_dbg(st0));
    dmem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave), .state_dbg(st3));

    logic [7:0]  mem_b [2][NBYTES];
    logic [31:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        if (d == 0) begin
            b0.req_valid = v; b0.req_we = we; b0.req_funct3 = f3; b0.req_addr = a; b0.req_wdata = wd;
        end else begin
            b3.req_valid = v; b3.req_we = we; b3.req_funct3 = f3; b3.req_addr = a; b3.req_wdata = wd;
        end
    endtask

    task automatic sample(input int d, output logic rv, output logic rdy, output logic [31:0] rd, output logic flt);
        if (d == 0) begin
            rv = b0.resp_valid; rdy = b0.req_ready; rd = b0.resp_rdata; flt = b0.resp_fault;
        end else begin
            rv = b3.resp_valid; rdy = b3.req_ready; rd = b3.resp_rdata; flt = b3.resp_fault;
        end
    endtask

    // Reference: memory as a flat byte array, sizes and faults from the ISA rules.
    function automatic void model(input int d, input logic we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic flt);
        int size;
        logic illegal;
        longint addr;
        logic [31:0] v;
        illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
        size = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
        if (illegal) size = 4;
        addr = longint'(a);
        rd = 32'h0;
        flt = 1'b0;
`ifdef DMEM_FAULT_EN
        flt = illegal || (addr % size != 0) || (addr >= NBYTES);
`else
        addr = addr % NBYTES;
        addr = addr - addr % size;
`endif
        if (flt) return;
        if (we) begin
            for (int i = 0; i < size; i++) mem_b[d][addr + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = mem_b[d][addr + i];
            if (!f3[2] && size < 4 && v[8*size-1])
                for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
            rd = v;
        end
    endfunction

    task automatic wait_ready(input int d);
        logic rv, rdy, flt;
        logic [31:0] rd;
        int n;
        n = 0;
        sample(d, rv, rdy, rd, flt);
        while (!rdy && n < 50) begin
            @(negedge clk);
            sample(d, rv, rdy, rd, flt);
            n++;
        end
        if (!rdy) check("ready_timeout", {31'b0, rdy}, 32'h1);
    endtask

    task automatic txn(input int d, input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic rv, rdy, flt, exp_f;
        logic [31:0] rd, exp_rd, got;
        int wc;
        wc = (d == 0) ? 0 : 3;
        model(d, we, f3, a, wd, exp_rd, exp_f);
        exp_q.push_back(exp_rd);
        @(negedge clk);
        wait_ready(d);
        drive(d, 1'b1, we, f3, a, wd);
        @(posedge clk);
        for (int c = 0; c <= wc + 1; c++) begin
            @(negedge clk);
            sample(d, rv, rdy, rd, flt);
            check("busy_ready", {31'b0, rdy}, 32'h0);
            check("resp_valid", {31'b0, rv}, 32'(c == wc + 1));
            if (c < wc + 1) begin
                // Junk on the bus while busy must be ignored.
                drive(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom), $urandom, $urandom);
            end else begin
                drive(d, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
                got = exp_q.pop_front();
                check("resp_rdata", rd, got);
                check("resp_fault", {31'b0, flt}, {31'b0, exp_f});
            end
        end
        @(negedge clk);
        sample(d, rv, rdy, rd, flt);
        check("ready_back", {31'b0, rdy}, 32'h1);
        check("resp_drop", {31'b0, rv}, 32'h0);
        check("rdata_hold", rd, exp_rd);
    endtask

    logic        rv_s, rdy_s, flt_s, dummy_f;
    logic [31:0] rd_s, dummy_rd;

    initial begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NBYTES; i++) mem_b[d][i] = 8'h00;
        drive(0, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);

        // Reset values.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sample(d, rv_s, rdy_s, rd_s, flt_s);
            check("rst_ready", {31'b0, rdy_s}, 32'h1);
            check("rst_valid", {31'b0, rv_s}, 32'h0);
            check("rst_rdata", rd_s, 32'h0);
            check("rst_fault", {31'b0, flt_s}, 32'h0);
        end
        rst = 1'b0;

        // Reset during BUSY aborts the store.
        @(negedge clk);
        wait_ready(1);
        drive(1, 1'b1, 1'b1, 3'b010, 32'h4, 32'h55);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        rst = 1'b1;
        #1;
        sample(1, rv_s, rdy_s, rd_s, flt_s);
        check("abort_ready", {31'b0, rdy_s}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        txn(1, 1'b0, 3'b010, 32'h4, 32'h0);

        // Reset during RESP: strobe drops at once, write stays committed.
        @(negedge clk);
        wait_ready(1);
        drive(1, 1'b1, 1'b1, 3'b010, 32'h8, 32'h12345678);
        model(1, 1'b1, 3'b010, 32'h8, 32'h12345678, dummy_rd, dummy_f);
        @(posedge clk);
        repeat (5) @(negedge clk);
        drive(1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        sample(1, rv_s, rdy_s, rd_s, flt_s);
        check("resp_before_rst", {31'b0, rv_s}, 32'h1);
        rst = 1'b1;
        #1;
        sample(1, rv_s, rdy_s, rd_s, flt_s);
        check("resp_rst_drop", {31'b0, rv_s}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        txn(1, 1'b0, 3'b010, 32'h8, 32'h0);

        // Directed load/store patterns on both instances.
        for (int d = 0; d < 2; d++) begin
            txn(d, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
            txn(d, 1'b0, 3'b010, 32'h10, 32'h0);
            txn(d, 1'b1, 3'b010, 32'h10, 32'h0);
            txn(d, 1'b1, 3'b000, 32'h11, 32'h7F);
            txn(d, 1'b0, 3'b010, 32'h10, 32'h0);
            txn(d, 1'b1, 3'b010, 32'h10, 32'h80000000);
            txn(d, 1'b0, 3'b000, 32'h13, 32'h0);
            txn(d, 1'b0, 3'b100, 32'h13, 32'h0);
            txn(d, 1'b1, 3'b001, 32'h22, 32'h8001);
            txn(d, 1'b0, 3'b001, 32'h22, 32'h0);
            txn(d, 1'b0, 3'b101, 32'h22, 32'h0);
            txn(d, 1'b0, 3'b010, 32'h20, 32'h0);
            txn(d, 1'b0, 3'b010, 32'h12, 32'h0);
            txn(d, 1'b1, 3'b010, NBYTES, 32'hA5A55A5A);
            txn(d, 1'b0, 3'b010, 32'h0, 32'h0);
            txn(d, 1'b1, 3'b100, 32'h30, 32'hCAFEF00D);
            txn(d, 1'b0, 3'b010, 32'h30, 32'h0);
            txn(d, 1'b0, 3'b111, 32'h10, 32'h0);
        end

        // Random traffic, mostly in range with some beyond the top.
        for (int k = 0; k < 160; k++) begin
            txn(k % 2, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                32'($urandom_range(0, NBYTES + 15)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
